// File: rtl/dmem_responder.sv
//------------------------------------------------------------------------------
// dmem_responder
//
// Data-memory slave for the CPU load/store port. It accepts one request at a
// time, waits LATENCY cycles, then returns a single one-cycle response. The
// storage is a word-organised RAM (2**ADDR_W words of 32 bits) with per-byte
// write enables. RAM contents are never cleared by reset.
//
// Timing, with the accept edge counted as edge 0:
//   edges 0..LATENCY-1 : accepted request sits in WAIT
//   edge  LATENCY      : RAM written (stores) / read (loads), enter RESP
//   edge  LATENCY+1    : back to IDLE, the next accept is possible
//   One request every LATENCY+2 cycles at best.
//
// Optional feature (compile-time macro DMEM_ERR_EN):
//   defined   : misaligned or out-of-range byte addresses return rsp_err=1,
//               rsp_rdata=0, and the RAM is not written.
//   undefined : rsp_err is always 0; the low two address bits and the bits
//               above the RAM range are ignored, so addresses wrap.
//
// Parameters:
//   ADDR_W   word-address bits (RAM depth 2**ADDR_W words), 1..29
//   LATENCY  wait cycles between accept and response, 0..15
//
// Ports:
//   clk        in   1   rising-edge clock
//   reset      in   1   asynchronous, active-high reset
//   req_valid  in   1   CPU presents a request
//   req_ready  out  1   responder can accept (high only in IDLE)
//   req_we     in   1   1 = store, 0 = load
//   req_addr   in   32  byte address
//   req_wdata  in   32  store data
//   req_be     in   4   byte enables; bit i writes bits [8i+7:8i]
//   rsp_valid  out  1   one-cycle response pulse
//   rsp_rdata  out  32  load data; 0 for stores, errors and outside rsp_valid
//   rsp_err    out  1   request rejected (only with DMEM_ERR_EN)
//   busy       out  1   high while a request is in WAIT or RESP
//------------------------------------------------------------------------------
module dmem_responder #(
  parameter int ADDR_W  = 10,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy
);

  // Reject unsupported configurations while elaborating.
  generate
    if ((LATENCY < 0) || (LATENCY > 15)) begin : g_bad_latency
      $error("dmem_responder: LATENCY must be within 0..15");
    end
    if ((ADDR_W < 1) || (ADDR_W > 29)) begin : g_bad_addr_w
      $error("dmem_responder: ADDR_W must be within 1..29");
    end
  endgenerate

  localparam int         DEPTH    = 2 ** ADDR_W;
  localparam logic       LAT_ZERO = (LATENCY == 0);
  // WAIT leaves when the counter is zero, so it is loaded with LATENCY-1.
  localparam logic [3:0] LAT_LOAD = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t      r_state;
  logic [3:0]  r_wait_cnt;
  logic        r_we;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [3:0]  r_be;
  logic        r_req_ready;
  logic        r_rsp_valid;
  logic [31:0] r_rsp_rdata;
  logic        r_rsp_err;
  logic        r_busy;
  logic [31:0] r_mem [DEPTH];

  logic              w_cur_we;
  logic [31:0]       w_cur_addr;
  logic [31:0]       w_cur_wdata;
  logic [3:0]        w_cur_be;
  logic [ADDR_W-1:0] w_word;
  logic              w_addr_err;
  logic              w_enter_resp;
  logic              w_ram_we;
  logic [31:0]       w_rdata_next;

`ifdef DMEM_ERR_EN
  // Misaligned byte address, or any address bit above the RAM range set.
  function automatic logic f_addr_err(input logic [31:0] addr);
    logic [31:0] hi_mask;
    hi_mask = ~((32'd1 << (ADDR_W + 2)) - 32'd1);
    return (addr[1:0] != 2'b00) || ((addr & hi_mask) != 32'd0);
  endfunction

  assign w_addr_err = f_addr_err(w_cur_addr);
`else
  logic w_unused_addr_bits;

  assign w_addr_err         = 1'b0;
  // Byte offset and out-of-range bits are ignored; the address wraps.
  assign w_unused_addr_bits = ^{w_cur_addr[1:0], w_cur_addr[31:ADDR_W+2]};
`endif

  // Request seen at the edge that enters RESP. With LATENCY=0 that edge is the
  // accept edge itself, so the fields come straight from the inputs.
  always_comb begin
    w_cur_we    = r_we;
    w_cur_addr  = r_addr;
    w_cur_wdata = r_wdata;
    w_cur_be    = r_be;
    if (r_state == S_IDLE) begin
      w_cur_we    = req_we;
      w_cur_addr  = req_addr;
      w_cur_wdata = req_wdata;
      w_cur_be    = req_be;
    end else begin
      w_cur_we    = r_we;
      w_cur_addr  = r_addr;
      w_cur_wdata = r_wdata;
      w_cur_be    = r_be;
    end
  end

  assign w_word       = w_cur_addr[ADDR_W+1:2];
  assign w_enter_resp = ((r_state == S_IDLE) && req_valid && LAT_ZERO) ||
                        ((r_state == S_WAIT) && (r_wait_cnt == 4'd0));
  assign w_ram_we     = w_enter_resp && w_cur_we && !w_addr_err && !reset;
  assign w_rdata_next = (!w_cur_we && !w_addr_err) ? r_mem[w_word] : 32'd0;

  // RAM write port: only enabled bytes of a good store, on the RESP-entry edge.
  always_ff @(posedge clk) begin
    if (w_ram_we) begin
      for (int b = 0; b < 4; b++) begin
        if (w_cur_be[b]) begin
          r_mem[w_word][8*b +: 8] <= w_cur_wdata[8*b +: 8];
        end
      end
    end
  end

  // Control FSM: sequences accept -> wait -> response and owns every output.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_wait_cnt  <= 4'd0;
      r_we        <= 1'b0;
      r_addr      <= 32'd0;
      r_wdata     <= 32'd0;
      r_be        <= 4'd0;
      r_req_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= 32'd0;
      r_rsp_err   <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_we        <= req_we;
            r_addr      <= req_addr;
            r_wdata     <= req_wdata;
            r_be        <= req_be;
            r_req_ready <= 1'b0;
            r_busy      <= 1'b1;
            if (LAT_ZERO) begin
              r_state     <= S_RESP;
              r_rsp_valid <= 1'b1;
              r_rsp_rdata <= w_rdata_next;
              r_rsp_err   <= w_addr_err;
            end else begin
              r_state    <= S_WAIT;
              r_wait_cnt <= LAT_LOAD;
            end
          end
        end
        S_WAIT: begin
          if (r_wait_cnt == 4'd0) begin
            r_state     <= S_RESP;
            r_rsp_valid <= 1'b1;
            r_rsp_rdata <= w_rdata_next;
            r_rsp_err   <= w_addr_err;
          end else begin
            r_wait_cnt <= r_wait_cnt - 4'd1;
          end
        end
        S_RESP: begin
          r_state     <= S_IDLE;
          r_req_ready <= 1'b1;
          r_busy      <= 1'b0;
          r_rsp_valid <= 1'b0;
          r_rsp_rdata <= 32'd0;
          r_rsp_err   <= 1'b0;
        end
        default: begin
          r_state     <= S_IDLE;
          r_wait_cnt  <= 4'd0;
          r_req_ready <= 1'b1;
          r_busy      <= 1'b0;
          r_rsp_valid <= 1'b0;
          r_rsp_rdata <= 32'd0;
          r_rsp_err   <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready = r_req_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;
  assign busy      = r_busy;

endmodule

// File: tb/tb_dmem_responder.sv
//------------------------------------------------------------------------------
// tb_dmem_responder
//
// Two responders side by side: index 0 with LATENCY=2, index 1 with LATENCY=0.
// A bench-side model tracks, per responder, the cycles since the last accept
// and a byte-level image of memory; a negedge process compares every output
// of both responders against it each cycle. Directed sequences add literal
// expectations for latency, byte-enable merging, address errors/aliasing and
// reset in the middle of a request.
//------------------------------------------------------------------------------
module tb_dmem_responder;

  localparam int ADDR_W = 10;
  localparam int WORDS  = 1024;
  localparam int LAT0   = 2;
  localparam int LAT1   = 0;

  logic        clk;
  logic        reset;
  logic        req_valid [2];
  logic        req_ready [2];
  logic        req_we    [2];
  logic [31:0] req_addr  [2];
  logic [31:0] req_wdata [2];
  logic [3:0]  req_be    [2];
  logic        rsp_valid [2];
  logic [31:0] rsp_rdata [2];
  logic        rsp_err   [2];
  logic        busy      [2];

  int checks = 0;
  int errors = 0;

  dmem_responder #(.ADDR_W(ADDR_W), .LATENCY(LAT0)) u_dut_l2 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_be(req_be[0]),
    .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0]),
    .busy(busy[0])
  );

  dmem_responder #(.ADDR_W(ADDR_W), .LATENCY(LAT1)) u_dut_l0 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_be(req_be[1]),
    .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1]),
    .busy(busy[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int i, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d] got %h expected %h at %0t", nm, i, act, exp, $time);
    end
  endtask

  function automatic int lat_of(input int i);
    return (i == 0) ? LAT0 : LAT1;
  endfunction

  // Address rule stated on byte addresses: word aligned and inside the RAM.
  function automatic bit addr_bad(input logic [31:0] a);
`ifdef DMEM_ERR_EN
    return ((a % 32'd4) != 32'd0) || (a >= 32'(4 * WORDS));
`else
    return (a === 32'hx);
`endif
  endfunction

  // ---------------- behavioural model ----------------
  logic [31:0] m_mem    [2][WORDS];
  bit   [3:0]  m_kn     [2][WORDS];
  bit          m_have   [2];
  int          m_phase  [2];
  bit          m_st_pend[2];
  int          m_st_word[2];
  logic [31:0] m_st_data[2];
  logic [3:0]  m_st_be  [2];
  logic [31:0] m_rdata  [2];
  bit          m_err    [2];
  bit          m_known  [2];

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 2; i++) begin
        m_have[i]    = 1'b0;
        m_phase[i]   = 0;
        m_st_pend[i] = 1'b0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if ((!m_have[i] || (m_phase[i] >= lat_of(i) + 1)) && req_valid[i]) begin
          m_have[i]    = 1'b1;
          m_phase[i]   = 0;
          m_err[i]     = addr_bad(req_addr[i]);
          m_st_word[i] = int'((req_addr[i] / 32'd4) % 32'(WORDS));
          m_st_data[i] = req_wdata[i];
          m_st_be[i]   = req_be[i];
          m_st_pend[i] = req_we[i] && !m_err[i];
          if (!req_we[i] && !m_err[i]) begin
            m_rdata[i] = m_mem[i][m_st_word[i]];
            m_known[i] = (m_kn[i][m_st_word[i]] == 4'hF);
          end else begin
            m_rdata[i] = 32'd0;
            m_known[i] = 1'b1;
          end
        end else if (m_have[i] && (m_phase[i] < lat_of(i) + 2)) begin
          m_phase[i]++;
        end
        if (m_have[i] && (m_phase[i] == lat_of(i)) && m_st_pend[i]) begin
          for (int b = 0; b < 4; b++) begin
            if (m_st_be[i][b]) begin
              m_mem[i][m_st_word[i]][8*b +: 8] = m_st_data[i][8*b +: 8];
              m_kn[i][m_st_word[i]][b] = 1'b1;
            end
          end
          m_st_pend[i] = 1'b0;
        end
      end
    end
  end

  // Every-cycle comparison of both responders against the model.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      bit ev;
      bit eb;
      bit er;
      ev = m_have[i] && (m_phase[i] == lat_of(i));
      eb = m_have[i] && (m_phase[i] <= lat_of(i));
      er = !m_have[i] || (m_phase[i] >= lat_of(i) + 1);
      chk("req_ready", i, 32'(req_ready[i]), 32'(er));
      chk("busy", i, 32'(busy[i]), 32'(eb));
      chk("rsp_valid", i, 32'(rsp_valid[i]), 32'(ev));
      if (ev) begin
        chk("rsp_err", i, 32'(rsp_err[i]), 32'(m_err[i]));
        if (m_known[i]) chk("rsp_rdata", i, rsp_rdata[i], m_rdata[i]);
      end else begin
        chk("idle_err", i, 32'(rsp_err[i]), 32'd0);
        chk("idle_rdata", i, rsp_rdata[i], 32'd0);
      end
    end
  end

  // One request on responder i; called and returns at a negedge.
  task automatic do_req(input int i, input bit we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] be,
                        output logic [31:0] rdata, output bit err, output int lat);
    int guard;
    guard = 0;
    rdata = 32'd0;
    err   = 1'b0;
    while ((req_ready[i] !== 1'b1) && (guard < 50)) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout[%0d] got req_ready=%b expected 1", i, req_ready[i]);
    end
    req_valid[i] = 1'b1;
    req_we[i]    = we;
    req_addr[i]  = addr;
    req_wdata[i] = wdata;
    req_be[i]    = be;
    @(posedge clk);
    @(negedge clk);
    // Scramble the request lines: the responder must ignore them now.
    req_valid[i] = 1'b0;
    req_we[i]    = ~we;
    req_addr[i]  = 32'hFFFF_FFFC;
    req_wdata[i] = ~wdata;
    req_be[i]    = 4'hF;
    lat = 1;
    while ((rsp_valid[i] !== 1'b1) && (lat < 40)) begin
      @(negedge clk);
      lat++;
    end
    if (lat >= 40) begin
      checks++;
      errors++;
      $display("FAIL rsp_timeout[%0d] got rsp_valid=%b expected 1", i, rsp_valid[i]);
    end
    rdata = rsp_rdata[i];
    err   = rsp_err[i];
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] rd;
    bit          er;
    int          lat;
    int          acc;
    int          rsp;
    int          seen;

    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      req_valid[i] = 1'b0;
      req_we[i]    = 1'b0;
      req_addr[i]  = 32'd0;
      req_wdata[i] = 32'd0;
      req_be[i]    = 4'd0;
    end
    repeat (3) @(negedge clk);
    chk("rst_ready", 0, 32'(req_ready[0]), 32'd1);
    chk("rst_valid", 0, 32'(rsp_valid[0]), 32'd0);
    chk("rst_busy", 0, 32'(busy[0]), 32'd0);
    chk("rst_rdata", 0, rsp_rdata[0], 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Full-word store then load, LATENCY=2.
    do_req(0, 1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, rd, er, lat);
    chk("st_lat", 0, 32'(lat), 32'd3);
    chk("st_err", 0, 32'(er), 32'd0);
    chk("st_rdata", 0, rd, 32'd0);
    do_req(0, 1'b0, 32'h10, 32'h0, 4'h0, rd, er, lat);
    chk("ld_lat", 0, 32'(lat), 32'd3);
    chk("ld_data", 0, rd, 32'hDEAD_BEEF);

    // Partial store, bytes 0 and 2.
    do_req(0, 1'b1, 32'h10, 32'h1122_3344, 4'b0101, rd, er, lat);
    do_req(0, 1'b0, 32'h10, 32'h0, 4'h0, rd, er, lat);
    chk("be_merge", 0, rd, 32'hDE22_BE44);

    // be=0000 is a no-op store.
    do_req(0, 1'b1, 32'h10, 32'h0, 4'b0000, rd, er, lat);
    chk("be0_err", 0, 32'(er), 32'd0);
    do_req(0, 1'b0, 32'h10, 32'h0, 4'h0, rd, er, lat);
    chk("be0_keep", 0, rd, 32'hDE22_BE44);

`ifdef DMEM_ERR_EN
    do_req(0, 1'b0, 32'h12, 32'h0, 4'h0, rd, er, lat);
    chk("mis_err", 0, 32'(er), 32'd1);
    chk("mis_rdata", 0, rd, 32'd0);
    chk("mis_lat", 0, 32'(lat), 32'd3);
    do_req(0, 1'b1, 32'h0, 32'h1234_5678, 4'hF, rd, er, lat);
    do_req(0, 1'b1, 32'h1000, 32'h55AA_55AA, 4'hF, rd, er, lat);
    chk("oor_err", 0, 32'(er), 32'd1);
    do_req(0, 1'b0, 32'h0, 32'h0, 4'h0, rd, er, lat);
    chk("oor_nowrite", 0, rd, 32'h1234_5678);
    chk("oor_ok_err", 0, 32'(er), 32'd0);
`else
    do_req(0, 1'b1, 32'h1000, 32'h55AA_55AA, 4'hF, rd, er, lat);
    chk("alias_err", 0, 32'(er), 32'd0);
    do_req(0, 1'b0, 32'h0, 32'h0, 4'h0, rd, er, lat);
    chk("alias_word0", 0, rd, 32'h55AA_55AA);
    do_req(0, 1'b0, 32'h12, 32'h0, 4'h0, rd, er, lat);
    chk("alias_off", 0, rd, 32'hDE22_BE44);
    chk("alias_off_err", 0, 32'(er), 32'd0);
`endif

    // Reset while a store sits in WAIT.
    do_req(0, 1'b1, 32'h20, 32'h0102_0304, 4'hF, rd, er, lat);
    req_valid[0] = 1'b1;
    req_we[0]    = 1'b1;
    req_addr[0]  = 32'h20;
    req_wdata[0] = 32'hCAFE_F00D;
    req_be[0]    = 4'hF;
    @(posedge clk);
    #2;
    req_valid[0] = 1'b0;
    chk("wait_busy", 0, 32'(busy[0]), 32'd1);
    #1 reset = 1'b1;
    #1;
    chk("mid_rst_ready", 0, 32'(req_ready[0]), 32'd1);
    chk("mid_rst_valid", 0, 32'(rsp_valid[0]), 32'd0);
    chk("mid_rst_busy", 0, 32'(busy[0]), 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (rsp_valid[0] === 1'b1) seen++;
    end
    chk("no_rsp_after_rst", 0, 32'(seen), 32'd0);
    do_req(0, 1'b0, 32'h20, 32'h0, 4'h0, rd, er, lat);
    chk("store_dropped", 0, rd, 32'h0102_0304);

    // LATENCY=0 with req_valid held high: accept every second cycle.
    req_valid[1] = 1'b1;
    req_we[1]    = 1'b1;
    req_addr[1]  = 32'h40;
    req_wdata[1] = 32'h0BAD_CAFE;
    req_be[1]    = 4'hF;
    acc = 0;
    rsp = 0;
    for (int k = 0; k < 8; k++) begin
      if (req_ready[1] === 1'b1) acc++;
      if (rsp_valid[1] === 1'b1) rsp++;
      @(negedge clk);
    end
    req_valid[1] = 1'b0;
    chk("b2b_accepts", 1, 32'(acc), 32'd4);
    chk("b2b_rsps", 1, 32'(rsp), 32'd4);
    do_req(1, 1'b0, 32'h40, 32'h0, 4'h0, rd, er, lat);
    chk("l0_lat", 1, 32'(lat), 32'd1);
    chk("l0_data", 1, rd, 32'h0BAD_CAFE);

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Hard stop if the sequence above ever stalls.
  initial begin
    #200000;
    $display("FAIL watchdog got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
